path_word_packer: RTL

- Sits directly downstream of the save-path character generator.
- Walks the generator's byte address space and captures each ASCII character, which arrives one cycle after its address.
- Packs four characters per word, big-endian, into 32-bit words and appends a NUL terminator.
- Writes the words through a valid/ready port into the bridge-side path buffer that the APF dataslot write command points at.

---
 rtl/path_word_packer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/path_word_packer.sv
// Packs the generator's path characters four per word, big-endian,
// and writes the NUL-terminated result into the path buffer.
module path_word_packer #(
    parameter int unsigned PATH_LENGTH     = 32,
    parameter int unsigned BASE_WORD_ADDR  = 0,
    parameter int unsigned WORD_ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 path_addr,
    input  logic [7:0]                 path_q,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [WORD_ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]                wr_data
);

    // One extra byte for the NUL, rounded up to whole words.
    localparam int unsigned WORD_COUNT = (PATH_LENGTH + 1 + 3) / 4;
    localparam int unsigned BYTE_COUNT = 4 * WORD_COUNT;
    localparam int unsigned BYTE_W     = $clog2(BYTE_COUNT + 1);
    localparam int unsigned WORD_W     = $clog2(WORD_COUNT + 1);
    localparam int unsigned AW         = WORD_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [BYTE_W-1:0]   r_byte_idx;
    logic [WORD_W-1:0]   r_word_idx;
    logic [31:0]         r_sr;
    logic                r_busy;
    logic                r_done;
    logic [7:0]          r_path_addr;
    logic                r_wr_valid;
    logic [AW-1:0]       r_wr_addr;
    logic [31:0]         r_wr_data;

    logic                w_fetch;
    logic [7:0]          w_byte;
    logic [31:0]         w_sr_next;
    logic                w_word_end;
    logic [BYTE_W-1:0]   w_byte_idx_next;
    logic [7:0]          w_path_addr_next;
    logic                w_last_word;
    logic [AW-1:0]       w_wr_addr;

    // Bytes past the path are the NUL pad and never touch the generator.
    assign w_fetch          = r_byte_idx < BYTE_W'(PATH_LENGTH);
    assign w_byte           = w_fetch ? path_q : 8'h00;
    assign w_sr_next        = {r_sr[23:0], w_byte};
    assign w_word_end       = (r_byte_idx[1:0] == 2'd3);
    assign w_byte_idx_next  = r_byte_idx + BYTE_W'(1);
    assign w_path_addr_next = (w_byte_idx_next < BYTE_W'(PATH_LENGTH)) ?
                              8'(w_byte_idx_next) : 8'(PATH_LENGTH - 1);
    assign w_last_word      = (r_word_idx == WORD_W'(WORD_COUNT - 1));
    assign w_wr_addr        = AW'(BASE_WORD_ADDR) + AW'(r_word_idx);

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_byte_idx  <= '0;
            r_word_idx  <= '0;
            r_sr        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_path_addr <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= AW'(BASE_WORD_ADDR);
            r_wr_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= S_ISSUE;
                        r_byte_idx  <= '0;
                        r_word_idx  <= '0;
                        r_sr        <= '0;
                        r_path_addr <= '0;
                        r_wr_addr   <= AW'(BASE_WORD_ADDR);
                        r_busy      <= 1'b1;
                    end
                end
                S_ISSUE, S_CAPTURE: begin
                    if (r_state == S_ISSUE && w_fetch) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        // Capture: shift byte in and point the generator at the next one.
                        r_sr        <= w_sr_next;
                        r_byte_idx  <= w_byte_idx_next;
                        r_path_addr <= w_path_addr_next;
                        if (w_word_end) begin
                            r_wr_data  <= w_sr_next;
                            r_wr_addr  <= w_wr_addr;
                            r_wr_valid <= 1'b1;
                            r_state    <= S_WRITE;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        r_wr_valid <= 1'b0;
                        r_word_idx <= r_word_idx + WORD_W'(1);
                        if (w_last_word) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign path_addr = r_path_addr;
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

endmodule
